// File: rtl/wb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
package wb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam logic M_HOST = 1'b0;
  localparam logic M_UART = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Index of the master owning a one-hot {m1,m0} grant.
  function automatic logic grant_idx(input logic [1:0] grant);
    return grant[1] ? M_UART : M_HOST;
  endfunction

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle for the arbiter: both master ports and the shared slave port.
// The slave modport is the arbiter's view, the master modport the surrounding system's.
interface wb_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_WIDTH-1:0] m0_adr_i;
  logic [DATA_WIDTH-1:0] m0_dat_i, m0_dat_o;
  logic                  m0_ack_o, m0_err_o;

  logic                  m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_WIDTH-1:0] m1_adr_i;
  logic [DATA_WIDTH-1:0] m1_dat_i, m1_dat_o;
  logic                  m1_ack_o, m1_err_o;

  logic                  s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_WIDTH-1:0] s_adr_o;
  logic [DATA_WIDTH-1:0] s_dat_o, s_dat_i;
  logic                  s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational two-way round-robin selector returning a one-hot pick.
module wb_rr_picker
  import wb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  // A tie goes to whichever master was not served last.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (last == M_UART) ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave Wishbone arbiter: round-robin, grant locked for the
// whole cycle, with a wait-state timeout that answers the stuck master with err.
module wb_mem_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic              clk,
  input  logic              rst,
  wb_mem_arbiter_if.slave   bus,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  arb_state_t            state_r;
  logic [1:0]            grant_r;
  logic                  last_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  logic [1:0]            pick_s;
  logic                  g_cyc_s, g_stb_s, g_we_s;
  logic [ADDR_WIDTH-1:0] g_adr_s;
  logic [DATA_WIDTH-1:0] g_dat_s;
  logic [CNT_WIDTH-1:0]  cnt_inc_s;
  logic                  stall_s, expire_s, live_s, abort_s, ack_s, err_s;

  wb_rr_picker u_picker (
    .req  ({bus.m1_cyc_i, bus.m0_cyc_i}),
    .last (last_r),
    .pick (pick_s)
  );

  // Select the signals of whichever master currently holds the grant.
  always_comb begin
    g_cyc_s = 1'b0;
    g_stb_s = 1'b0;
    g_we_s  = 1'b0;
    g_adr_s = {ADDR_WIDTH{1'b0}};
    g_dat_s = {DATA_WIDTH{1'b0}};
    if (grant_r[1]) begin
      g_cyc_s = bus.m1_cyc_i;
      g_stb_s = bus.m1_stb_i;
      g_we_s  = bus.m1_we_i;
      g_adr_s = bus.m1_adr_i;
      g_dat_s = bus.m1_dat_i;
    end else if (grant_r[0]) begin
      g_cyc_s = bus.m0_cyc_i;
      g_stb_s = bus.m0_stb_i;
      g_we_s  = bus.m0_we_i;
      g_adr_s = bus.m0_adr_i;
      g_dat_s = bus.m0_dat_i;
    end else begin
      g_cyc_s = 1'b0;
    end
  end

  // Wait-state accounting; expiry is flagged on the stall that reaches the limit.
  always_comb begin
    cnt_inc_s = cnt_r + CNT_ONE;
    stall_s   = g_stb_s & ~bus.s_ack_i;
    expire_s  = (TIMEOUT_CYCLES != 0) && stall_s && (cnt_inc_s == TO_LIMIT);
  end

  // Arbitration FSM, grant ownership and timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      grant_r <= 2'b00;
      last_r  <= M_UART;
      cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_WIDTH{1'b0}};
          if (pick_s != 2'b00) begin
            grant_r <= pick_s;
            state_r <= BUSY;
          end else begin
            grant_r <= 2'b00;
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (!g_cyc_s) begin
            state_r <= IDLE;
            last_r  <= grant_idx(grant_r);
            grant_r <= 2'b00;
            cnt_r   <= {CNT_WIDTH{1'b0}};
          end else if (expire_s) begin
            state_r <= ABORT;
            cnt_r   <= {CNT_WIDTH{1'b0}};
          end else if (stall_s) begin
            cnt_r   <= cnt_inc_s;
          end else begin
            cnt_r   <= {CNT_WIDTH{1'b0}};
          end
        end
        ABORT: begin
          state_r <= IDLE;
          last_r  <= grant_idx(grant_r);
          grant_r <= 2'b00;
          cnt_r   <= {CNT_WIDTH{1'b0}};
        end
        default: begin
          state_r <= IDLE;
          grant_r <= 2'b00;
          cnt_r   <= {CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Bus routing; reset low silences everything so a pending ack never escapes.
  always_comb begin
    live_s  = rst & (state_r == BUSY);
    abort_s = rst & (state_r == ABORT);
    ack_s   = live_s & g_cyc_s & g_stb_s & bus.s_ack_i;
    err_s   = abort_s & g_cyc_s & g_stb_s;

    bus.s_cyc_o = live_s & g_cyc_s;
    bus.s_stb_o = live_s & g_stb_s;
    bus.s_we_o  = live_s & g_we_s;
    bus.s_adr_o = live_s ? g_adr_s : {ADDR_WIDTH{1'b0}};
    bus.s_dat_o = live_s ? g_dat_s : {DATA_WIDTH{1'b0}};

    bus.m0_ack_o = ack_s & grant_r[0];
    bus.m0_err_o = err_s & grant_r[0];
    bus.m0_dat_o = (live_s & grant_r[0]) ? bus.s_dat_i : {DATA_WIDTH{1'b0}};
    bus.m1_ack_o = ack_s & grant_r[1];
    bus.m1_err_o = err_s & grant_r[1];
    bus.m1_dat_o = (live_s & grant_r[1]) ? bus.s_dat_i : {DATA_WIDTH{1'b0}};
  end

  assign o_grant = grant_r;
  assign o_busy  = (state_r == BUSY);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level ownership model.
module tb_wb_mem_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] o_grant;
  logic       o_busy;

  always #5 clk = ~clk;

  wb_mem_arbiter_if bus ();

  wb_mem_arbiter #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_grant (o_grant),
    .o_busy  (o_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the slave, who was served last, stall length.
  int owner, last_m, stall;
  bit aborting;

  int         acks[2];
  int         errs[2];
  int         gseq[$];
  logic [1:0] prev_grant;

  // Autonomous master/slave behaviour for the looping phases.
  bit          act[2];
  int          beats[2];
  logic        we_v[2];
  logic [31:0] adr_v[2];
  logic [31:0] dat_v[2];
  int req_pct, stb_pct, ack_pct, max_beats, rst_pml;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_cyc(input int k);
    return (k == 1) ? bus.m1_cyc_i : bus.m0_cyc_i;
  endfunction
  function automatic logic m_stb(input int k);
    return (k == 1) ? bus.m1_stb_i : bus.m0_stb_i;
  endfunction
  function automatic logic m_we(input int k);
    return (k == 1) ? bus.m1_we_i : bus.m0_we_i;
  endfunction
  function automatic logic [31:0] m_adr(input int k);
    return (k == 1) ? bus.m1_adr_i : bus.m0_adr_i;
  endfunction
  function automatic logic [31:0] m_dat(input int k);
    return (k == 1) ? bus.m1_dat_i : bus.m0_dat_i;
  endfunction

  task automatic check_outputs();
    bit live, ab, gc, gs;
    logic ack_obs, err_obs;
    logic [31:0] dat_obs;
    gc   = (owner >= 0) ? m_cyc(owner) : 1'b0;
    gs   = (owner >= 0) ? m_stb(owner) : 1'b0;
    live = rst && owner >= 0 && !aborting;
    ab   = rst && owner >= 0 && aborting;
    check_eq("grant", o_grant, (owner < 0) ? 32'd0 : ((owner == 0) ? 32'd1 : 32'd2));
    check_eq("busy", o_busy, owner >= 0 && !aborting);
    check_eq("s_cyc", bus.s_cyc_o, live && gc);
    check_eq("s_stb", bus.s_stb_o, live && gs);
    check_eq("s_we", bus.s_we_o, live && m_we(owner));
    check_eq("s_adr", bus.s_adr_o, live ? m_adr(owner) : 32'd0);
    check_eq("s_dat", bus.s_dat_o, live ? m_dat(owner) : 32'd0);
    for (int k = 0; k < 2; k++) begin
      ack_obs = (k == 1) ? bus.m1_ack_o : bus.m0_ack_o;
      err_obs = (k == 1) ? bus.m1_err_o : bus.m0_err_o;
      dat_obs = (k == 1) ? bus.m1_dat_o : bus.m0_dat_o;
      check_eq($sformatf("m%0d_ack", k), ack_obs, live && owner == k && gc && gs && bus.s_ack_i);
      check_eq($sformatf("m%0d_err", k), err_obs, ab && owner == k && gc && gs);
      check_eq($sformatf("m%0d_dat", k), dat_obs, (live && owner == k) ? bus.s_dat_i : 32'd0);
      if (ack_obs === 1'b1) acks[k]++;
      if (err_obs === 1'b1) errs[k]++;
    end
    if (o_grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(o_grant[1] ? 1 : 0);
    prev_grant = o_grant;
  endtask

  task automatic model_next();
    if (!rst) begin
      owner = -1; last_m = 1; stall = 0; aborting = 1'b0;
    end else if (owner < 0) begin
      stall = 0;
      if (m_cyc(0) && m_cyc(1)) owner = 1 - last_m;
      else if (m_cyc(0))        owner = 0;
      else if (m_cyc(1))        owner = 1;
    end else if (aborting) begin
      last_m = owner; owner = -1; aborting = 1'b0;
    end else if (!m_cyc(owner)) begin
      last_m = owner; owner = -1; stall = 0;
    end else if (m_stb(owner) && !bus.s_ack_i) begin
      stall++;
      if (stall == TO) begin aborting = 1'b1; stall = 0; end
    end else begin
      stall = 0;
    end
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic advance();
    model_next();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (k == 1) begin
      bus.m1_cyc_i = cyc; bus.m1_stb_i = stb; bus.m1_we_i = we; bus.m1_adr_i = adr; bus.m1_dat_i = dat;
    end else begin
      bus.m0_cyc_i = cyc; bus.m0_stb_i = stb; bus.m0_we_i = we; bus.m0_adr_i = adr; bus.m0_dat_i = dat;
    end
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'd0;
    act[0] = 1'b0;
    act[1] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    idle_all();
    for (int i = 0; i < n; i++) begin settle(); advance(); end
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b0;
    settle();
    advance();
    rst = 1'b1;
  endtask

  task automatic drive_auto();
    for (int k = 0; k < 2; k++)
      set_m(k, act[k], act[k] && ($urandom_range(99) < stb_pct), we_v[k], adr_v[k], dat_v[k]);
    bus.s_ack_i = ($urandom_range(99) < ack_pct);
    bus.s_dat_i = $urandom;
    rst = (rst_pml == 0) ? 1'b1 : ($urandom_range(999) >= rst_pml);
  endtask

  task automatic update_auto();
    logic ack_obs, err_obs;
    for (int k = 0; k < 2; k++) begin
      ack_obs = (k == 1) ? bus.m1_ack_o : bus.m0_ack_o;
      err_obs = (k == 1) ? bus.m1_err_o : bus.m0_err_o;
      if (act[k]) begin
        if (err_obs) act[k] = 1'b0;
        else if (ack_obs) begin
          beats[k]--;
          if (beats[k] <= 0) act[k] = 1'b0;
        end
      end else if ($urandom_range(99) < req_pct) begin
        act[k]   = 1'b1;
        beats[k] = $urandom_range(max_beats, 1);
        we_v[k]  = $urandom_range(1, 0);
        adr_v[k] = $urandom;
        dat_v[k] = $urandom;
      end
    end
  endtask

  task automatic run_auto(input int n);
    for (int i = 0; i < n; i++) begin
      drive_auto();
      settle();
      update_auto();
      advance();
    end
  endtask

  initial begin
    int exp_alt[4];
    exp_alt = '{0, 1, 0, 1};
    prev_grant = 2'b00;
    rst = 1'b0;
    idle_all();
    @(posedge clk);
    @(negedge clk);
    owner = -1; last_m = 1; stall = 0; aborting = 1'b0;

    // Reset state, then release
    do_reset();
    check_eq("rst_grant", o_grant, 32'd0);

    // m1 single write with two wait states
    acks[0] = 0; acks[1] = 0;
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    settle(); check_eq("wr_lat_idle", bus.s_cyc_o, 32'd0); advance();
    settle(); check_eq("wr_s_cyc", bus.s_cyc_o, 32'd1);
    check_eq("wr_s_adr", bus.s_adr_o, 32'h0000_0010);
    check_eq("wr_s_dat", bus.s_dat_o, 32'hDEAD_BEEF); advance();
    settle(); advance();
    bus.s_ack_i = 1'b1;
    settle(); check_eq("wr_m1_ack", bus.m1_ack_o, 32'd1); advance();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.s_ack_i = 1'b0;
    settle(); advance();
    settle(); check_eq("wr_release", o_grant, 32'd0); advance();
    check_eq("wr_m1_acks", acks[1], 32'd1);
    check_eq("wr_m0_acks", acks[0], 32'd0);

    // Both request straight after reset, then keep re-requesting
    do_reset();
    gseq.delete();
    req_pct = 100; stb_pct = 100; ack_pct = 100; max_beats = 1; rst_pml = 0;
    run_auto(20);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("alt_%0d", i), (i < gseq.size()) ? gseq[i] : 32'hFFFF_FFFF, exp_alt[i]);
    req_pct = 0;
    run_auto(6);
    idle_cycles(2);

    // m0 read
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'd0);
    bus.s_dat_i = 32'h1234_5678;
    settle(); advance();
    bus.s_ack_i = 1'b1;
    settle();
    check_eq("rd_m0_ack", bus.m0_ack_o, 32'd1);
    check_eq("rd_m0_dat", bus.m0_dat_o, 32'h1234_5678);
    check_eq("rd_m1_dat", bus.m1_dat_o, 32'd0);
    advance();
    idle_cycles(2);

    // Timeout on m1, late ack ignored, m0 next
    errs[1] = 0; acks[1] = 0;
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_AAAA);
    settle(); advance();
    for (int i = 1; i <= TO; i++) begin
      if (i == 5) set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
      settle();
      check_eq("to_stall_cyc", bus.s_cyc_o, 32'd1);
      check_eq("to_stall_err", bus.m1_err_o, 32'd0);
      advance();
    end
    bus.s_ack_i = 1'b1;
    settle();
    check_eq("to_err", bus.m1_err_o, 32'd1);
    check_eq("to_s_cyc", bus.s_cyc_o, 32'd0);
    check_eq("to_no_ack", bus.m1_ack_o, 32'd0);
    advance();
    settle();
    check_eq("to_late_ack", bus.m1_ack_o, 32'd0);
    check_eq("to_idle_grant", o_grant, 32'd0);
    advance();
    bus.s_ack_i = 1'b0;
    settle(); check_eq("to_next_m0", o_grant, 32'd1); advance();
    check_eq("to_err_count", errs[1], 32'd1);
    idle_cycles(3);

    // m0 burst of three beats while m1 waits
    acks[0] = 0;
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0BAD_F00D);
    settle(); advance();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0090, 32'd0);
    for (int i = 0; i < 6; i++) begin
      bus.m0_stb_i = (i % 2 == 0);
      bus.s_ack_i  = (i % 2 == 0);
      settle(); check_eq("burst_hold", o_grant, 32'd1); advance();
    end
    check_eq("burst_beats", acks[0], 32'd3);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.s_ack_i = 1'b0;
    settle(); advance();
    settle(); check_eq("burst_gap", o_grant, 32'd0); advance();
    settle(); check_eq("burst_then_m1", o_grant, 32'd2); advance();
    bus.s_ack_i = 1'b1;
    settle(); check_eq("burst_m1_ack", bus.m1_ack_o, 32'd1); advance();
    idle_cycles(3);

    // Reset while m0 waits for an ack
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'd0);
    settle(); advance();
    settle(); check_eq("rb_grant", o_grant, 32'd1); advance();
    rst = 1'b0;
    bus.s_ack_i = 1'b1;
    settle(); check_eq("rb_no_ack", bus.m0_ack_o, 32'd0); advance();
    rst = 1'b1;
    bus.s_ack_i = 1'b0;
    settle();
    check_eq("rb_grant_clr", o_grant, 32'd0);
    check_eq("rb_s_cyc", bus.s_cyc_o, 32'd0);
    advance();
    settle(); check_eq("rb_regrant", o_grant, 32'd1); advance();
    idle_cycles(2);

    // Randomized traffic with occasional resets
    req_pct = 40; stb_pct = 85; ack_pct = 35; max_beats = 3; rst_pml = 5;
    run_auto(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
Two-master to one-slave Wishbone arbiter. It shares the user-area memory port between the host/management master (m0) and the UART-to-Wishbone bridge (m1). Arbitration is round-robin with the grant locked for the whole Wishbone cycle. A per-transaction timeout returns an error to any master whose slave never acks.

Parameters:
DATA_WIDTH, 32, data bus width for all ports
ADDR_WIDTH, 32, address bus width for all ports
TIMEOUT_CYCLES, 1024, wait-state limit before abort; 0 disables the timeout
CNT_WIDTH, 11, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
m0_cyc_i / m0_stb_i / m0_we_i  in  1 each  host master cycle, strobe, write enable
m0_adr_i  in  ADDR_WIDTH  host address
m0_dat_i  in  DATA_WIDTH  host write data
m0_dat_o  out  DATA_WIDTH  host read data
m0_ack_o / m0_err_o  out  1 each  host acknowledge, host timeout error
m1_*  same set as m0_*  UART bridge master
s_cyc_o / s_stb_o / s_we_o  out  1 each  to memory slave
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_dat_i  in  DATA_WIDTH  slave read data
s_ack_i  in  1  slave acknowledge
o_grant  out  2  one-hot current grant {m1,m0}; 00 = none
o_busy  out  1  high in state BUSY

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, grant=00, last=m1 (so m0 wins the first tie), timeout counter=0.
  - All outputs are 0 during and after reset until the first grant.
  - Reset mid-transaction aborts immediately. No ack or err is issued.
- FSM states: IDLE, BUSY, ABORT.
- IDLE:
  - No cyc asserted: stay in IDLE.
  - Exactly one cyc asserted: grant that master.
  - Both asserted: grant the master that is not `last`.
  - The grant is registered: next state is BUSY with grant set one cycle after cyc is sampled. Minimum request-to-slave latency is 1 cycle.
- BUSY:
  - s_cyc/s_stb/s_we/s_adr/s_dat_o are combinationally muxed from the granted master.
  - s_ack_i is routed to the granted master's ack_o, and s_dat_i to its dat_o.
  - The non-granted master sees ack=0, err=0, dat_o=0.
  - Grant is held while the granted cyc stays high. Multiple stb/ack beats (burst or RMW) stay with the same master.
  - Granted cyc low: return to IDLE, update last=granted, grant=00. This costs one mandatory idle cycle between tenures.
- Timeout:
  - In BUSY, the counter increments each cycle with granted stb=1 and s_ack_i=0.
  - It clears on s_ack_i=1 or when stb=0.
  - When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), go to ABORT.
- ABORT (exactly 1 cycle):
  - s_cyc_o=s_stb_o=0.
  - Granted master gets err_o=1, ack_o=0.
  - Next state is IDLE, with last=granted and grant=00.
  - A late s_ack_i arriving in ABORT or IDLE is ignored and never forwarded.
- s_ack_i when no master is granted, or while stb=0: ignored.
- ack_o and err_o are never asserted in the same cycle.
- Each is asserted only while the receiving master's cyc and stb are both 1.
- Both masters requesting continuously alternate grants: m0, m1, m0, ... with no starvation.

Decomposition:
- Shared package `wb_pkg`:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, ABORT=2'd2)
  - master index localparams (M_HOST=0, M_UART=1)
  - DATA_WIDTH/ADDR_WIDTH defaults
- One natural sub-module: `wb_rr_picker`. It is a combinational 2-way round-robin selector taking req[1:0] and last, and returning a one-hot pick.
- FSM, timeout counter and muxing stay in the top level.

Test Plan:
- m1 single write (adr=0x0000_0010, dat=0xDEAD_BEEF), slave acks after 2 wait states:
  - s_cyc rises 1 cycle after m1_cyc.
  - m1_ack_o pulses once.
  - m0_ack_o stays 0.
  - o_grant returns to 00 one cycle after m1_cyc drops.
- m0 and m1 raise cyc in the same cycle straight after reset:
  - m0 is served first, then m1 after one idle cycle.
  - Repeat with both held high: grant order is m0, m1, m0, m1.
- m0 read at 0x0000_0100, slave returns 0x1234_5678:
  - m0_dat_o = 0x1234_5678 in the ack cycle.
  - m1_dat_o = 0.
- TIMEOUT_CYCLES=8, m1 strobes and the slave never acks:
  - After 8 stalled cycles, one cycle of ABORT: m1_err_o=1, s_cyc_o=0.
  - A subsequent s_ack_i is not forwarded.
  - m0 is granted next.
- m0 holds cyc across 3 stb/ack beats while m1 requests:
  - m1 is not granted until m0_cyc drops, then granted after the idle cycle.
- rst=0 asserted mid-BUSY with the ack pending:
  - Next cycle all outputs are 0 and o_grant=00.
  - After rst=1, a fresh m0 request is granted normally.
